gf_mul_serial: RTL
==================

# gf_mul_serial

Parametrised digit-serial GF(2^WIDTH) multiplier with a valid/ready start handshake and an optional accumulate mode. Computes o_state = (i_state_1 · i_state_2 mod P(x)) XOR (i_acc_en ? i_acc : 0), where P(x) = x^WIDTH + POLY. It processes DIGIT multiplier bits per cycle, so the MixColumns and key-schedule datapaths can trade area for latency. It is the generalised successor of the fixed 8-bit bit-serial GF multiplier.

## Interface
- WIDTH, 8, field degree m; operand and result width.
- POLY, 8'h1B, low WIDTH bits of the irreducible polynomial; x^WIDTH is implied. The default is the AES field 0x11B.
- DIGIT, 1, multiplier bits processed per cycle. Must divide WIDTH; otherwise it is an elaboration error.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- i_start  in  1  request; accepted on an edge where i_start=1 and o_ready=1.
- o_ready  out  1  high in IDLE.
- i_state_1  in  WIDTH  multiplicand a; sampled at accept.
- i_state_2  in  WIDTH  multiplier b; sampled at accept.
- i_acc_en  in  1  accumulate-mode select; sampled at accept.
- i_acc  in  WIDTH  accumulate addend; sampled at accept.
- o_state  out  WIDTH  result register; holds until the next completion.
- o_done  out  1  one-cycle pulse when o_state updates.

## Operation
- Defined constant: N = WIDTH/DIGIT.
- FSM states:
  - IDLE: o_ready=1.
  - BUSY: o_ready=0.
- Transitions:
  - IDLE→BUSY on accept.
  - BUSY→IDLE on the N-th BUSY edge.
- At accept, capture a, b, and acc_sel = (i_acc_en ? i_acc : 0). Clear the partial product p and the digit counter.
- Each BUSY edge runs DIGIT MSB-first Horner steps, back to back and combinationally. One step is: p ← xtime(p) XOR (b[msb] ? a : 0), then b ← b<<1.
- xtime(p) = (p<<1)[WIDTH-1:0] XOR (p[WIDTH-1] ? POLY : 0).
- On the final BUSY edge: o_state ← final p XOR acc_sel, o_done ← 1.
- All arithmetic is WIDTH-bit XOR, with no carries. Operand changes after accept have no effect.
- i_start while BUSY is ignored; no queueing.
- Zero operand: the result is acc_sel.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - o_state=0, o_done=0, p=0, counter=0.
  - o_ready=1 from the first post-reset cycle.
- Latency: accept on edge k gives o_done=1 and a valid o_state in the cycle after edge k+N. Default N=8, so o_done is seen 9 edges after accept.
- o_done is high for exactly one cycle. It clears on the next edge unless that edge itself completes a new operation.
- o_ready = (state==IDLE), combinational from state. It is high in the o_done cycle, so a new start can be accepted on that same edge. Sustained throughput is one result per N+1 cycles.
- Reset mid-BUSY aborts the operation: no o_done pulse, and o_state is forced to 0.
- rst_n=0 with i_start=1 on the same edge: reset wins and nothing is accepted.

## Structure
- Shared package gf_pkg holds:
  - AES_POLY = 8'h1B
  - AES_WIDTH = 8
  - function gf_xtime(p, poly), width-generic.
- Sub-module gf_digit_step (combinational) chains DIGIT Horner steps. Inputs: p, a, top DIGIT bits of b. Output: next p. It is reusable by a future fully-parallel multiplier (DIGIT=WIDTH).
- Top level holds the FSM, counter, operand registers and the output register.

## Test plan
- Default params, no accumulate:
  - 0x26·0x9E → 0x2F.
  - 0x0F·0x15 → 0xC3.
  - 0x01·0x03 → 0x03.
  - Each o_done arrives 9 edges after accept, with a one-cycle pulse.
- FIPS-197 vector:
  - 0x57·0x83 → 0xC1.
  - The same operation with i_acc_en=1 and i_acc=0xC1 → 0x00.
  - 0x57·0x13 → 0xFE.
- Back-to-back: hold i_start=1 continuously → accepts every 9 cycles. i_start pulses during BUSY are ignored, and operands changed mid-op do not alter the result.
- WIDTH=4, POLY=4'h3, DIGIT=2: 0x7·0x9 → 0xA with o_done 3 edges after accept. With DIGIT=4, the same 0xA arrives after 2 edges.
- Reset:
  - rst_n=0 at BUSY cycle 4 → no o_done, o_state=0, o_ready=1 next cycle.
  - A following 0x00·0xFF → 0x00.
- Random regression: 1000 random a, b, acc across DIGIT ∈ {1,2,4,8}, checked against a bit-serial reference model.

Source files
------------

// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared GF(2^m) constants, FSM state type and xtime helper
//
// Purpose: common definitions for the GF multiplier family.
//   AES_WIDTH / AES_POLY : AES field x^8 + x^4 + x^3 + x + 1 (0x11B).
//   gf_state_e           : IDLE/BUSY states of the serial multiplier.
//   gf_xtime()           : multiply by x modulo x^width + poly, for any width
//                          up to GF_MAX_WIDTH.
package gf_pkg;

  localparam int         AES_WIDTH    = 8;
  localparam logic [7:0] AES_POLY     = 8'h1B;
  localparam int         GF_MAX_WIDTH = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } gf_state_e;

  // Operands are zero-extended to GF_MAX_WIDTH bits; only the low 'width'
  // bits of the result are meaningful (the rest are masked to zero).
  function automatic logic [GF_MAX_WIDTH-1:0] gf_xtime(
    input logic [GF_MAX_WIDTH-1:0] p,
    input logic [GF_MAX_WIDTH-1:0] poly,
    input int                      width
  );
    logic [GF_MAX_WIDTH-1:0] mask;
    logic                    msb;
    mask = (width >= GF_MAX_WIDTH) ? '1
                                   : ((GF_MAX_WIDTH'(1) << width) - GF_MAX_WIDTH'(1));
    msb  = |(p & (GF_MAX_WIDTH'(1) << (width - 1)));
    return ((p << 1) & mask) ^ (msb ? (poly & mask) : '0);
  endfunction

endpackage

// File: rtl/gf_digit_step.sv
// rtl/gf_digit_step.sv - combinational chain of DIGIT MSB-first Horner steps
//
// Purpose: one digit of a GF(2^WIDTH) multiplication. Each step computes
//   p <- xtime(p) ^ (b_bit ? a : 0), consuming b_top from its MSB downward.
// Ports:
//   p      in  WIDTH  partial product entering this digit
//   a      in  WIDTH  multiplicand
//   b_top  in  DIGIT  the next DIGIT multiplier bits, MSB first
//   p_next out WIDTH  partial product after DIGIT steps
module gf_digit_step
  import gf_pkg::*;
#(
  parameter int               WIDTH = AES_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = AES_POLY,
  parameter int               DIGIT = 1
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] a,
  input  logic [DIGIT-1:0] b_top,
  output logic [WIDTH-1:0] p_next
);

  always_comb begin
    p_next = p;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      p_next = WIDTH'(gf_xtime(GF_MAX_WIDTH'(p_next), GF_MAX_WIDTH'(POLY), WIDTH))
               ^ (b_top[i] ? a : '0);
    end
  end

endmodule

// File: rtl/gf_mul_serial.sv
// rtl/gf_mul_serial.sv - digit-serial GF(2^WIDTH) multiplier with accumulate
//
// Purpose: o_state = (a * b mod x^WIDTH + POLY) ^ (acc_en ? acc : 0),
//   DIGIT multiplier bits per cycle, WIDTH/DIGIT busy cycles per operation.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_start / o_ready start handshake, accepted when both are high
//   i_state_1         multiplicand a (sampled at accept)
//   i_state_2         multiplier b (sampled at accept)
//   i_acc_en, i_acc   accumulate select and addend (sampled at accept)
//   o_state           result register, held until the next completion
//   o_done            one-cycle pulse when o_state updates
module gf_mul_serial
  import gf_pkg::*;
#(
  parameter int               WIDTH = AES_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = AES_POLY,
  parameter int               DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_state_1,
  input  logic [WIDTH-1:0] i_state_2,
  input  logic             i_acc_en,
  input  logic [WIDTH-1:0] i_acc,
  output logic [WIDTH-1:0] o_state,
  output logic             o_done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("gf_mul_serial: DIGIT must divide WIDTH");
  end

  gf_state_e        state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] p_next;
  logic [CW-1:0]    cnt;

  gf_digit_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .DIGIT (DIGIT)
  ) u_step (
    .p      (p),
    .a      (a_r),
    .b_top  (b_r[WIDTH-1 -: DIGIT]),
    .p_next (p_next)
  );

  assign o_ready = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      p       <= '0;
      cnt     <= '0;
      o_state <= '0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            a_r   <= i_state_1;
            b_r   <= i_state_2;
            acc_r <= i_acc_en ? i_acc : '0;
            p     <= '0;
            cnt   <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          p   <= p_next;
          // Consumed multiplier bits shift out so the next digit sits on top.
          b_r <= b_r << DIGIT;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            o_state <= p_next ^ acc_r;
            o_done  <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
